// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath word, register index and the memory-stage FSM states.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // Link register written by jal.
    localparam regbits_t LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache port between the memory stage and the data cache.
// Handshake: the stage raises dmemREN or dmemWEN with dmemaddr/dmemstore and
// holds them stable until the cache returns dhit; the access completes in the
// cycle where dhit=1 (dmemload valid in that same cycle for reads). dhit may
// already be high in the request cycle, which completes the access with no stall.
interface mem_stage_if;
    import cpu_types_pkg::*;

    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );

endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: data-cache request, stall generation, branch/jump
// resolution, write-back register and sticky halt.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,          // synchronous, active-high
    input  logic               dREN_in,
    input  logic               dWEN_in,
    input  logic               RegWr_in,
    input  logic               MemtoReg_in,
    input  logic               lui_in,
    input  logic               jal_in,
    input  logic               beq_in,
    input  logic               bne_in,
    input  logic               jump_in,
    input  logic               jr_in,
    input  logic               flagZero_in,
    input  logic               halt_in,
    input  word_t              alu_in,
    input  word_t              rdat1_in,
    input  word_t              rdat2_in,
    input  word_t              pcplusfour_in,
    input  word_t              Ext_addr_in,
    input  logic [25:0]        j_addr_in,
    input  logic [15:0]        imm_in,
    input  regbits_t           wsel_in,
    mem_stage_if.master        dmem,
    output logic               stall_mem,
    output logic               redirect,
    output word_t              pc_target,
    output logic               flush,
    output logic               wb_RegWr,
    output regbits_t           wb_wsel,
    output word_t              wb_wdat,
    output logic               wb_halt,
    output word_t              stall_count,
    output mem_state_t         state_dbg
);

    mem_state_t state_q, state_d;
    logic       wb_regwr_q, wb_regwr_d;
    regbits_t   wb_wsel_q, wb_wsel_d;
    word_t      wb_wdat_q, wb_wdat_d;
    logic       wb_halt_q, wb_halt_d;
    word_t      stall_count_q, stall_count_d;

    logic       mop;
    logic       taken;
    word_t      target;

    // Cache request, stall and control-transfer resolution.
    always_comb begin
        mop            = (dREN_in | dWEN_in) && (state_q != HALTED);
        dmem.dmemREN   = dREN_in & mop;
        dmem.dmemWEN   = dWEN_in & mop;
        dmem.dmemaddr  = alu_in;
        dmem.dmemstore = rdat2_in;
        stall_mem      = mop & ~dmem.dhit;

        taken  = 1'b0;
        target = pcplusfour_in;
        if (!stall_mem && (state_q != HALTED)) begin
            if (jr_in) begin
                taken  = 1'b1;
                target = rdat1_in;
            end else if (jump_in | jal_in) begin
                taken  = 1'b1;
                target = {pcplusfour_in[31:28], j_addr_in, 2'b00};
            end else if ((beq_in & flagZero_in) | (bne_in & ~flagZero_in)) begin
                taken  = 1'b1;
                target = pcplusfour_in + (Ext_addr_in << 2);
            end
        end
        redirect  = taken;
        flush     = taken;
        pc_target = target;
    end

    // Next-state logic: wait out cache misses, enter HALTED once halt is unstalled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (halt_in && !stall_mem)  state_d = HALTED;
                else if (stall_mem)         state_d = WAIT;
            end
            WAIT: begin
                if (halt_in && !stall_mem)  state_d = HALTED;
                else if (dmem.dhit)         state_d = RUN;
            end
            HALTED:                         state_d = HALTED;
            default:                        state_d = RUN;
        endcase
    end

    // Write-back capture: bubble while stalled, frozen-and-halted once HALTED.
    always_comb begin
        wb_regwr_d    = wb_regwr_q;
        wb_wsel_d     = wb_wsel_q;
        wb_wdat_d     = wb_wdat_q;
        wb_halt_d     = wb_halt_q;
        stall_count_d = stall_count_q + {31'd0, stall_mem};

        if (state_q == HALTED) begin
            wb_regwr_d = 1'b0;
            wb_halt_d  = 1'b1;
        end else if (stall_mem) begin
            wb_regwr_d = 1'b0;
            wb_halt_d  = 1'b0;
        end else begin
            wb_regwr_d = RegWr_in;
            wb_halt_d  = halt_in;
            wb_wsel_d  = jal_in ? LINK_REG : wsel_in;
            if (jal_in)            wb_wdat_d = pcplusfour_in;
            else if (lui_in)       wb_wdat_d = {imm_in, 16'h0000};
            else if (MemtoReg_in)  wb_wdat_d = dmem.dmemload;
            else                   wb_wdat_d = alu_in;
        end
    end

    // State, write-back latch and stall counter registers.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q       <= RUN;
            wb_regwr_q    <= 1'b0;
            wb_wsel_q     <= '0;
            wb_wdat_q     <= '0;
            wb_halt_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wb_regwr_q    <= wb_regwr_d;
            wb_wsel_q     <= wb_wsel_d;
            wb_wdat_q     <= wb_wdat_d;
            wb_halt_q     <= wb_halt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign wb_RegWr    = wb_regwr_q;
    assign wb_wsel     = wb_wsel_q;
    assign wb_wdat     = wb_wdat_q;
    assign wb_halt     = wb_halt_q;
    assign stall_count = stall_count_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM latch and feeding the register-file write port. It issues data-cache reads and writes, freezes the upstream pipeline until the cache answers, resolves branches and jumps, and registers the write-back result. It also latches halt as a sticky condition.

## Interface
- No parameters. Widths come from `cpu_types_pkg`: `word_t` is 32 bits, `regbits_t` is 5 bits.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: reset, synchronous and active-high. The stage resets on a rising `CLK` edge while `nRST`=1.
- `dREN_in`, `dWEN_in`, `RegWr_in`, `MemtoReg_in`, `lui_in`, `jal_in`, `beq_in`, `bne_in`, `jump_in`, `jr_in`, `flagZero_in`, `halt_in` in 1 each: control signals from the EX/MEM latch.
- `alu_in`, `rdat1_in`, `rdat2_in`, `pcplusfour_in`, `Ext_addr_in` in 32 each: datapath values from EX/MEM.
- `j_addr_in` in 26: jump target field.
- `imm_in` in 16: immediate for lui.
- `wsel_in` in 5: destination register.
- `dhit` in 1: data cache has completed the access.
- `dmemload` in 32: read data from the cache.
- `dmemREN`, `dmemWEN` out 1: cache request.
- `dmemaddr`, `dmemstore` out 32: access address and store data.
- `stall_mem` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `redirect` out 1: taken control transfer.
- `pc_target` out 32: new PC.
- `flush` out 1: clears IF/ID and ID/EX.
- `wb_RegWr` out 1, `wb_wsel` out 5, `wb_wdat` out 32, `wb_halt` out 1: registered write-back outputs.
- `stall_count` out 32: number of memory-stall cycles.

## Operation
- FSM states, held in `mem_state_t`: `RUN`, `WAIT`, `HALTED`.
- Memory-op active (`mop`) = (`dREN_in` | `dWEN_in`) and state ≠ `HALTED`.
- `dmemREN` = `dREN_in`&`mop`. `dmemWEN` = `dWEN_in`&`mop`. `dmemaddr` = `alu_in`. `dmemstore` = `rdat2_in`. These are combinational.
- `stall_mem` = `mop` & ~`dhit`, combinational.
- Transitions:
  - `RUN` goes to `WAIT` when `mop` & ~`dhit`.
  - `WAIT` goes to `RUN` on `dhit`.
  - `RUN` or `WAIT` goes to `HALTED` when `halt_in` & ~`stall_mem`.
  - `HALTED` is left only by reset.
- Control transfer is evaluated only when ~`stall_mem` and state ≠ `HALTED`. Priority order:
  1. `jr_in`: target = `rdat1_in`.
  2. `jump_in` | `jal_in`: target = {`pcplusfour_in`[31:28], `j_addr_in`, 2'b00}.
  3. (`beq_in`&`flagZero_in`) | (`bne_in`&~`flagZero_in`): target = `pcplusfour_in` + (`Ext_addr_in`<<2), 32-bit with wraparound.
- When a transfer is taken, `redirect`=`flush`=1 and `pc_target` = target. Otherwise `redirect`=`flush`=0 and `pc_target` = `pcplusfour_in`.
- Write-back data selection, in priority order:
  1. `jal_in`: `pcplusfour_in`, and `wb_wsel` is forced to 31.
  2. `lui_in`: {`imm_in`, 16'h0}.
  3. `MemtoReg_in`: `dmemload`, sampled on the `dhit` cycle.
  4. Otherwise: `alu_in`.
- When `stall_mem`=1 the write-back register captures a bubble: `wb_RegWr`=0, `wb_halt`=0, other fields hold.
- `stall_count` increments by 1 on each edge where `stall_mem`=1. It wraps at 2^32−1 back to 0.

## Timing
- Reset: state=`RUN`. `wb_RegWr`, `wb_wsel`, `wb_wdat`, `wb_halt` and `stall_count` are all 0. Combinational outputs follow the inputs immediately.
- Reset asserted mid-access (state `WAIT`) takes effect at that edge. The request drops in the next cycle unless the inputs still request.
- Latency: a non-memory instruction appears on `wb_*` 1 cycle after it is presented.
- A memory op whose `dhit` comes N cycles after presentation (N≥0) appears on `wb_*` N+1 cycles after presentation. It stalls for N cycles.
- `dhit` in the same cycle as the request gives zero stall and never enters `WAIT`.
- Halt with ~`stall_mem` at edge k gives `wb_halt`=1 from k+1 onward, sticky. From that point `dmemREN`=`dmemWEN`=`redirect`=0 and `wb_RegWr`=0.
- A halt that is stalled behind its own memory op completes that op first.
- The EX/MEM latch holds its values while `stall_mem`=1. Inputs are assumed stable for the whole access.

## Structure
- `mem_state_t` enum, added to `cpu_types_pkg`. Reuse `word_t` and `regbits_t` from the same package.
- One module. A separate `mem_wb` latch sub-module is optional. If it is split out it is named `mem_wb`, and the bubble insertion stays in `mem_stage`.

## Test plan
- Reset then idle: all `wb_*` = 0. Add `alu_in`=0x10, `RegWr_in`=1, `wsel_in`=5 → next cycle `wb_wdat`=0x10, `wb_wsel`=5, `wb_RegWr`=1.
- Load `alu_in`=0x100, `dhit` held low for 3 cycles, `dmemload`=0xDEADBEEF → `stall_mem`=1 for 3 cycles and `stall_count`=3. `wb_wdat`=0xDEADBEEF appears 4 cycles after presentation, with bubbles before it.
- `beq_in`=1, `flagZero_in`=1, `pcplusfour_in`=0x40, `Ext_addr_in`=0xFFFFFFFF → `redirect`=`flush`=1, `pc_target`=0x3C.
- `jal_in`=1, `pcplusfour_in`=0x1004, `j_addr_in`=0x40 → `pc_target`=0x100. Next cycle `wb_wsel`=31, `wb_wdat`=0x1004.
- `halt_in`=1, then `dWEN_in`=1 on a later cycle → `wb_halt`=1 and sticky, `dmemWEN` stays 0.
- `nRST` asserted during a `WAIT` stall → next cycle state=`RUN`, `stall_count`=0, `wb_RegWr`=0.
